// File: rtl/aes_enc_engine.sv
// Iterative AES-128 encryptor with valid/ready handshakes and ROUNDS_PER_CYCLE unrolled rounds per clock.
// Define AES_CBC_EN to build in CBC chaining (iv / chain register pre-whitening); otherwise ECB only.
module aes_enc_engine #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int NUM_ROUNDS       = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] plaintext,
  input  logic [0:127] key,
  input  logic [0:127] iv,
  input  logic         chain_start,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] ciphertext,
  output logic         busy
);
  localparam int CW = $clog2(NUM_ROUNDS + 1);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
        ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_rpc
    $error("aes_enc_engine: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  // Entry 0 is unused so round r indexes byte r directly.
  localparam logic [0:87] RCON = 88'h00_01_02_04_08_10_20_40_80_1b_36;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = {b, 3'b000};
    return SBOX[idx +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [CW-1:0] r);
    logic [CW+2:0] idx;
    idx = {r, 3'b000};
    return RCON[idx +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [0:127] next_key(input logic [0:127] k, input logic [CW-1:0] r);
    logic [0:31]  t;
    logic [0:127] nk;
    t = {sbox(k[104:111]) ^ rcon(r), sbox(k[112:119]), sbox(k[120:127]), sbox(k[96:103])};
    nk[0:31]   = k[0:31] ^ t;
    nk[32:63]  = nk[0:31] ^ k[32:63];
    nk[64:95]  = nk[32:63] ^ k[64:95];
    nk[96:127] = nk[64:95] ^ k[96:127];
    return nk;
  endfunction

  function automatic logic [0:127] aes_round(input logic [0:127] s, input logic [0:127] rk,
                                             input logic last);
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [0:127] o;
    for (int i = 0; i < 16; i++) sb[i] = sbox(s[8*i +: 8]);
    // Bytes are column-major: byte 4c+r is row r of column c.
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[4*c + r] = sb[4*((c + r) % 4) + r];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c + 1];
      a2 = sr[4*c + 2];
      a3 = sr[4*c + 3];
      if (last) o[32*c +: 32] = {a0, a1, a2, a3};
      else      o[32*c +: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o ^ rk;
  endfunction

  state_e         fsm_q, fsm_d;
  logic [0:127]   state_q, state_d;
  logic [0:127]   key_q, key_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [0:127]   whiten;
  logic           handoff;

  logic [0:127] st_c [ROUNDS_PER_CYCLE+1];
  logic [0:127] rk_c [ROUNDS_PER_CYCLE+1];
  assign st_c[0] = state_q;
  assign rk_c[0] = key_q;

  for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
    logic [CW-1:0] rnd;
    assign rnd         = cnt_q + CW'(g + 1);
    assign rk_c[g + 1] = next_key(rk_c[g], rnd);
    assign st_c[g + 1] = aes_round(st_c[g], rk_c[g + 1], rnd == CW'(NUM_ROUNDS));
  end

`ifdef AES_CBC_EN
  logic [0:127] chain_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        chain_q <= '0;
    else if (handoff) chain_q <= state_q;
  end
  assign whiten = chain_start ? iv : chain_q;
`else
  logic unused_cbc;
  assign whiten     = '0;
  assign unused_cbc = ^{iv, chain_start, handoff};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      cnt_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    key_d     = key_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    handoff   = 1'b0;
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = plaintext ^ key ^ whiten;
          key_d   = key;
          cnt_d   = '0;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        busy    = 1'b1;
        state_d = st_c[ROUNDS_PER_CYCLE];
        key_d   = rk_c[ROUNDS_PER_CYCLE];
        cnt_d   = cnt_q + CW'(ROUNDS_PER_CYCLE);
        if (cnt_d == CW'(NUM_ROUNDS)) fsm_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          handoff = 1'b1;
          cnt_d   = '0;
          fsm_d   = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign ciphertext = state_q;

endmodule

// File: tb/tb_aes_enc_engine.sv
// Directed bench for aes_enc_engine: FIPS-197 / SP800-38A vectors across all unroll factors,
// back-pressure, and reset mid-block. Expectations follow AES_CBC_EN when it is defined.
module tb_aes_enc_engine;
  localparam logic [127:0] KEY_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] IV_F2   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_F1   = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] PT_F2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
`ifdef AES_CBC_EN
  localparam logic [127:0] EXP_F1  = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] EXP_F2  = 128'h5086cb9b507219ee95db113a917678b2;
`else
  localparam logic [127:0] EXP_F1  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] EXP_F2  = 128'hf5d3d58503b9699de785895a96fdbaaf;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [0:127] pt, key, iv;
  logic         cs, out_ready;
  logic         in_valid  [4];
  logic         in_ready  [4];
  logic         out_valid [4];
  logic         busy      [4];
  logic [0:127] ct        [4];
  int           tests = 0;
  int           fails = 0;
  int           lat;
  logic [127:0] c;

  always #5 clk = ~clk;

  aes_enc_engine #(.ROUNDS_PER_CYCLE(1)) u_r1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .plaintext(pt), .key(key), .iv(iv), .chain_start(cs), .out_valid(out_valid[0]),
    .out_ready(out_ready), .ciphertext(ct[0]), .busy(busy[0]));
  aes_enc_engine #(.ROUNDS_PER_CYCLE(2)) u_r2 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .plaintext(pt), .key(key), .iv(iv), .chain_start(cs), .out_valid(out_valid[1]),
    .out_ready(out_ready), .ciphertext(ct[1]), .busy(busy[1]));
  aes_enc_engine #(.ROUNDS_PER_CYCLE(5)) u_r5 (
    .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .plaintext(pt), .key(key), .iv(iv), .chain_start(cs), .out_valid(out_valid[2]),
    .out_ready(out_ready), .ciphertext(ct[2]), .busy(busy[2]));
  aes_enc_engine #(.ROUNDS_PER_CYCLE(10)) u_r10 (
    .clk(clk), .reset(reset), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .plaintext(pt), .key(key), .iv(iv), .chain_start(cs), .out_valid(out_valid[3]),
    .out_ready(out_ready), .ciphertext(ct[3]), .busy(busy[3]));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int idx);
    int n;
    n = 0;
    while (!in_ready[idx] && n < 50) begin
      tick();
      n++;
    end
    chk("accept_ready", 128'(in_ready[idx]), 128'd1);
  endtask

  // Latency counts the accept cycle as cycle 1, so the first out_valid cycle is the latency.
  task automatic run_block(input int idx, input logic [127:0] p, input logic [127:0] k,
                           input logic [127:0] v, input logic chain,
                           output int l, output logic [127:0] c_out);
    pt = p; key = k; iv = v; cs = chain;
    in_valid[idx] = 1'b1;
    wait_ready(idx);
    tick();
    in_valid[idx] = 1'b0;
    pt = ~p; key = ~k; iv = ~v;
    l = 1;
    while (!out_valid[idx] && l < 40) begin
      tick();
      l++;
    end
    c_out = ct[idx];
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; out_ready = 1'b1; cs = 1'b0;
    pt = '0; key = '0; iv = '0;
    for (int i = 0; i < 4; i++) in_valid[i] = 1'b0;
    tick(); tick();
    chk("rst_in_ready",  128'(in_ready[0]),  128'd1);
    chk("rst_out_valid", 128'(out_valid[0]), 128'd0);
    chk("rst_busy",      128'(busy[0]),      128'd0);
    chk("rst_ct",        ct[0],              128'd0);
    reset = 1'b0;
    tick();

    run_block(0, PT_C1, KEY_C1, '0, 1'b1, lat, c);
    chk("c1_ct",  c, CT_C1);
    chk("c1_lat", 128'(lat), 128'd11);

    run_block(1, PT_B, KEY_B, '0, 1'b1, lat, c);
    chk("b_rpc2_ct",  c, CT_B);
    chk("b_rpc2_lat", 128'(lat), 128'd6);
    run_block(2, PT_B, KEY_B, '0, 1'b1, lat, c);
    chk("b_rpc5_ct",  c, CT_B);
    chk("b_rpc5_lat", 128'(lat), 128'd3);
    run_block(3, PT_B, KEY_B, '0, 1'b1, lat, c);
    chk("b_rpc10_ct",  c, CT_B);
    chk("b_rpc10_lat", 128'(lat), 128'd2);

    // Stall the sink with a second block waiting at the input.
    out_ready = 1'b0;
    run_block(0, PT_B, KEY_B, '0, 1'b1, lat, c);
    chk("bp_ct",  c, CT_B);
    chk("bp_lat", 128'(lat), 128'd11);
    pt = PT_C1; key = KEY_C1; iv = '0; cs = 1'b1;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_hold_ct",    ct[0],              CT_B);
      chk("bp_hold_valid", 128'(out_valid[0]), 128'd1);
      chk("bp_hold_ready", 128'(in_ready[0]),  128'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_handoff_valid", 128'(out_valid[0]), 128'd0);
    chk("bp_handoff_ready", 128'(in_ready[0]),  128'd1);
    chk("bp_handoff_busy",  128'(busy[0]),      128'd0);
    run_block(0, PT_C1, KEY_C1, '0, 1'b1, lat, c);
    chk("bp_second_ct",  c, CT_C1);
    chk("bp_second_lat", 128'(lat), 128'd11);

    run_block(0, PT_F1, KEY_B, IV_F2, 1'b1, lat, c);
    chk("f_blk1_ct", c, EXP_F1);
    run_block(0, PT_F2, KEY_B, IV_F2, 1'b0, lat, c);
    chk("f_blk2_ct", c, EXP_F2);

    // Reset part-way through a block; the chain register must restart from zero.
    pt = PT_C1; key = KEY_C1; iv = '0; cs = 1'b1;
    in_valid[0] = 1'b1;
    wait_ready(0);
    tick();
    in_valid[0] = 1'b0;
    chk("mid_busy", 128'(busy[0]), 128'd1);
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 128'(out_valid[0]), 128'd0);
    chk("mid_rst_busy",      128'(busy[0]),      128'd0);
    chk("mid_rst_ct",        ct[0],              128'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rel_in_ready", 128'(in_ready[0]), 128'd1);
    run_block(0, PT_C1, KEY_C1, IV_F2, 1'b0, lat, c);
    chk("after_rst_ct",  c, CT_C1);
    chk("after_rst_lat", 128'(lat), 128'd11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/aes_enc_engine.md
Name: aes_enc_engine

Overview:
Iterative AES-128 encryption engine and parametrised successor to the fixed-latency Encrypt core. It replaces the free-running enable pulse with valid/ready handshakes on input and output. The number of rounds evaluated per clock is configurable, and CBC chaining across consecutive blocks is optional. It sits between the host block source and ciphertext sink and reuses the existing SubBytes/ShiftRows/MixColumns/AddRoundKey and key-schedule helpers.

Parameters:
ROUNDS_PER_CYCLE, 1, AES rounds unrolled per clock; legal values 1, 2, 5, 10; any other value is a compile-time error.
NUM_ROUNDS, 10, AES-128 round count; fixed, exposed only for the counter width.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  plaintext/key/iv present.
in_ready  output  1  engine can accept a block.
plaintext  input  [0:127]  block in; bit 0 is the MSB of byte 0.
key  input  [0:127]  cipher key, sampled per block.
iv  input  [0:127]  CBC initial vector, sampled when chain_start=1.
chain_start  input  1  block starts a new CBC chain.
out_valid  output  1  ciphertext valid.
out_ready  input  1  sink accepts ciphertext.
ciphertext  output  [0:127]  encrypted block.
busy  output  1  rounds in progress.

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0; busy=0; ciphertext=0; round counter=0; chain register=0.
- States:
  - IDLE: in_ready=1. An accept (in_valid&in_ready) latches the state as plaintext XOR key (XOR chain value first when CBC is active), latches key as the round-0 key, and moves to ROUND.
  - ROUND: each cycle applies ROUNDS_PER_CYCLE rounds. Each round advances the round key on the fly (rcon 01,02,04,08,10,20,40,80,1b,36). The final round omits MixColumns. When the counter reaches NUM_ROUNDS, the state moves to DONE.
  - DONE: out_valid=1; ciphertext holds steady while out_valid && !out_ready. On out_valid&&out_ready: move to IDLE, drop out_valid the next cycle, and load the chain register with ciphertext.
- Latency from accept to the first out_valid cycle: NUM_ROUNDS/ROUNDS_PER_CYCLE + 1 cycles (11, 6, 3, 2).
- Throughput: one block per latency+1 cycles when out_ready=1. No accept occurs in the same cycle as output handoff; in_ready asserts only in IDLE.
- in_valid while busy: ignored. The source holds its data until in_ready.
- busy=1 exactly in ROUND.
- Inputs are sampled only on the accept edge. Later changes to plaintext, key or iv do not affect the block in flight.
- Round counter width: clog2(NUM_ROUNDS+1). It never wraps past NUM_ROUNDS and clears on entry to IDLE.
- Reset mid-operation: the in-flight block is discarded, no out_valid is produced, and the chain register clears.
- out_ready=1 with out_valid=0 has no effect.

Optional Feature:
AES_CBC_EN
- Defined:
  - chain_start=1 on accept: the pre-whitening XOR uses iv.
  - chain_start=0: it uses the chain register (previous ciphertext).
  - First block after reset with chain_start=0 chains from 0.
- Undefined: ECB only. iv and chain_start are ignored, no chain register is synthesised, and pre-whitening is plaintext XOR key.

Test Plan:
- FIPS-197 C.1, ROUNDS_PER_CYCLE=1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid exactly 11 cycles after accept.
- FIPS-197 B, repeated for ROUNDS_PER_CYCLE 2, 5 and 10: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32; latency 6, 3 and 2 respectively.
- Back-pressure: hold out_ready=0 for 20 cycles after out_valid -> ciphertext stable, in_ready=0, second block not accepted until the handoff completes.
- AES_CBC_EN defined, SP800-38A F.2.1: key 2b7e..3c, iv 000102..0f with chain_start=1.
  - pt 6bc1bee22e409f96e93d7e117393172a -> 7649abac8119b246cee98e9b12e9197d.
  - Next pt ae2d8a571e03ac9c9eb76fac45af8e51 with chain_start=0 -> 5086cb9b507219ee95db113a917678b2.
- AES_CBC_EN undefined: same first pt and key, iv ignored -> 3ad77bb40d7a3660a89ecaf32466ef97 (ECB).
- Assert reset 4 cycles after accept -> out_valid, busy and ciphertext all 0 immediately, in_ready=1 after release. The next C.1 block yields the correct ct, and under AES_CBC_EN it is chained from 0.
